square_position_store: RTL and testbench

SQUARE_POSITION_STORE -- requirements
Module: square_position_store

---
 rtl/square_position_store.sv | 156 +++++++++++++++
 tb/tb_square_position_store.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/square_position_store.sv
// Square position store: holds the {y,x} origin of NUM_SQUARES squares,
// exposes the active square to the movement controller, captures its
// write-back two cycles after each refresh tick, and performs a per-pixel
// hit test against all squares for the video scan.
//
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous active-high reset
//   refresh_tick   one-cycle frame pulse (shared with the controller)
//   sel_next       one-cycle pulse: advance the active square ID
//   position_next  controller write-back {y[19:10], x[9:0]}
//   position       stored {y,x} of the active square (combinational)
//   status         high while the store is idle and the controller may update
//   active_id      current active square ID
//   x, y           current scan pixel coordinates
//   pixel_on       registered: scan pixel lies inside some square
//   pixel_id       registered: lowest covering square ID, 0 if none
//   pixel_active   registered: covering square is the active one
module square_position_store #(
    parameter int NUM_SQUARES = 17,
    parameter int SQUARE_SIZE = 30,
    parameter int X_MAX       = 640,
    parameter int Y_MAX       = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        refresh_tick,
    input  logic        sel_next,
    input  logic [19:0] position_next,
    output logic [19:0] position,
    output logic        status,
    output logic [4:0]  active_id,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    output logic        pixel_on,
    output logic [4:0]  pixel_id,
    output logic        pixel_active
);

    localparam int unsigned ID_W    = 5;
    localparam int unsigned COORD_W = 10;
    localparam int unsigned SUM_W   = 11;
    localparam int unsigned X_LIM   = X_MAX - SQUARE_SIZE;
    localparam int unsigned Y_LIM   = Y_MAX - SQUARE_SIZE;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [19:0]         entry [NUM_SQUARES];
    logic                pending;
    logic                pending_nxt;
    logic                wr_en;
    logic                advance;
    logic [COORD_W-1:0]  wr_x;
    logic [COORD_W-1:0]  wr_y;
    logic                hit;
    logic [ID_W-1:0]     hit_id;
    logic [SUM_W-1:0]    x_lo, x_hi, y_lo, y_hi;
    logic [SUM_W-1:0]    scan_x, scan_y;

    assign position = entry[active_id];
    assign status   = (state == ST_IDLE);

    // Next state, write strobe and active-ID advance; a select request is
    // only honoured in an idle cycle with no tick so the ID cannot move
    // between a tick and its capture.
    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        wr_en       = 1'b0;
        advance     = 1'b0;
        case (state)
            ST_IDLE:    if (refresh_tick) state_nxt = ST_WAIT;
            ST_WAIT:    state_nxt = ST_CAPTURE;
            ST_CAPTURE: begin
                state_nxt = ST_IDLE;
                wr_en     = 1'b1;
            end
            default:    state_nxt = ST_IDLE;
        endcase
        if (state == ST_IDLE && !refresh_tick) begin
            advance     = sel_next | pending;
            pending_nxt = 1'b0;
        end else if (sel_next) begin
            pending_nxt = 1'b1;
        end
    end

    // Clamp write-back so a square never extends past the display area.
    always_comb begin
        wr_x = (position_next[9:0] > COORD_W'(X_LIM)) ? COORD_W'(X_LIM) : position_next[9:0];
        wr_y = (position_next[19:10] > COORD_W'(Y_LIM)) ? COORD_W'(Y_LIM) : position_next[19:10];
    end

    // Control state, active ID and entry storage.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            pending   <= 1'b0;
            active_id <= '0;
            for (int i = 0; i < NUM_SQUARES; i++) begin
                entry[i] <= {10'd220, COORD_W'(10 + 36 * i)};
            end
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
            if (advance) begin
                active_id <= (active_id == ID_W'(NUM_SQUARES - 1)) ? '0 : active_id + ID_W'(1);
            end
            if (wr_en) begin
                entry[active_id] <= {wr_y, wr_x};
            end
        end
    end

    // Hit test; descending scan makes the lowest covering ID win.
    always_comb begin
        hit    = 1'b0;
        hit_id = '0;
        x_lo   = '0;
        x_hi   = '0;
        y_lo   = '0;
        y_hi   = '0;
        scan_x = {1'b0, x};
        scan_y = {1'b0, y};
        for (int i = NUM_SQUARES - 1; i >= 0; i--) begin
            x_lo = {1'b0, entry[i][9:0]};
            y_lo = {1'b0, entry[i][19:10]};
            x_hi = x_lo + SUM_W'(SQUARE_SIZE - 1);
            y_hi = y_lo + SUM_W'(SQUARE_SIZE - 1);
            if (scan_x >= x_lo && scan_x <= x_hi && scan_y >= y_lo && scan_y <= y_hi) begin
                hit    = 1'b1;
                hit_id = ID_W'(i);
            end
        end
    end

    // Registered pixel outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            pixel_on     <= 1'b0;
            pixel_id     <= '0;
            pixel_active <= 1'b0;
        end else begin
            pixel_on     <= hit;
            pixel_id     <= hit_id;
            pixel_active <= hit && (hit_id == active_id);
        end
    end

endmodule

// File: tb/tb_square_position_store.sv
// Randomized bench for square_position_store with a behavioural model.
module tb_square_position_store;

    localparam int N  = 17;
    localparam int SZ = 30;

    logic        clk = 1'b0;
    logic        reset;
    logic        refresh_tick;
    logic        sel_next;
    logic [19:0] position_next;
    logic [19:0] position;
    logic        status;
    logic [4:0]  active_id;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        pixel_on;
    logic [4:0]  pixel_id;
    logic        pixel_active;

    square_position_store dut (
        .clk           (clk),
        .reset         (reset),
        .refresh_tick  (refresh_tick),
        .sel_next      (sel_next),
        .position_next (position_next),
        .position      (position),
        .status        (status),
        .active_id     (active_id),
        .x             (x),
        .y             (y),
        .pixel_on      (pixel_on),
        .pixel_id      (pixel_id),
        .pixel_active  (pixel_active)
    );

    always #5 clk = ~clk;

    // Model: square origins, active square, pending select, and how many
    // cycles have elapsed since the last accepted tick (0 = idle).
    int m_x [N];
    int m_y [N];
    int m_act;
    bit m_pend;
    int m_phase;
    bit e_on;
    int e_id;
    bit e_act;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_x[i] = 10 + 36 * i;
            m_y[i] = 220;
        end
        m_act   = 0;
        m_pend  = 0;
        m_phase = 0;
        e_on    = 0;
        e_id    = 0;
        e_act   = 0;
    endfunction

    // One clock: drive inputs, check visible state, advance the model,
    // then check the registered pixel outputs after the edge.
    task automatic step(input bit r, input bit t, input bit s, input logic [19:0] pn,
                        input int px, input int py);
        int wx;
        int wy;
        reset         = r;
        refresh_tick  = t;
        sel_next      = s;
        position_next = pn;
        x             = 10'(px);
        y             = 10'(py);
        #1;
        chk("status", 32'(status), 32'(m_phase == 0));
        chk("active_id", 32'(active_id), 32'(m_act));
        chk("position", 32'(position), 32'(m_y[m_act] * 1024 + m_x[m_act]));
        if (r) begin
            model_reset();
        end else begin
            e_on = 0;
            e_id = 0;
            for (int i = N - 1; i >= 0; i--) begin
                if (px >= m_x[i] && px <= m_x[i] + SZ - 1 && py >= m_y[i] && py <= m_y[i] + SZ - 1) begin
                    e_on = 1;
                    e_id = i;
                end
            end
            e_act = e_on && (e_id == m_act);
            if (m_phase == 2) begin
                wx = int'(pn[9:0]);
                wy = int'(pn[19:10]);
                m_x[m_act] = (wx > 610) ? 610 : wx;
                m_y[m_act] = (wy > 450) ? 450 : wy;
            end
            if (m_phase == 0 && !t) begin
                if (s || m_pend) m_act = (m_act + 1) % N;
                m_pend = 0;
            end else if (s) begin
                m_pend = 1;
            end
            if (m_phase == 0) m_phase = t ? 1 : 0;
            else m_phase = (m_phase + 1) % 3;
        end
        @(posedge clk);
        #1;
        chk("pixel_on", 32'(pixel_on), 32'(e_on));
        chk("pixel_id", 32'(pixel_id), 32'(e_id));
        chk("pixel_active", 32'(pixel_active), 32'(e_act));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 20'd0, 0, 0);
    endtask

    initial begin
        int k;
        int px;
        int py;
        reset         = 1'b1;
        refresh_tick  = 1'b0;
        sel_next      = 1'b0;
        position_next = '0;
        x             = '0;
        y             = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        chk("rst_status", 32'(status), 32'd1);
        chk("rst_position", 32'(position), 32'({10'd220, 10'd10}));
        chk("rst_pixel_on", 32'(pixel_on), 32'd0);

        // Tick, then write-back {220,15} in the capture cycle.
        step(0, 1, 0, 20'd0, 0, 0);
        step(0, 0, 0, 20'd0, 0, 0);
        step(0, 0, 0, {10'd220, 10'd15}, 0, 0);
        step(0, 0, 0, 20'd0, 0, 0);
        chk("wb_entry0", 32'(position), 32'({10'd220, 10'd15}));

        // Full walk of active IDs with wrap.
        for (int i = 0; i < N; i++) step(0, 0, 1, 20'd0, 0, 0);
        chk("wrap_id", 32'(active_id), 32'd0);

        // Select coincident with tick plus a dropped second select.
        step(0, 1, 1, 20'd0, 0, 0);
        step(0, 0, 1, 20'd0, 0, 0);
        step(0, 0, 0, {10'd300, 10'd200}, 0, 0);
        chk("defer_id", 32'(active_id), 32'd0);
        step(0, 0, 0, 20'd0, 0, 0);
        chk("defer_apply", 32'(active_id), 32'd1);
        idle(1);

        // Clamp: x=630, y=470 on square 1.
        step(0, 1, 0, 20'd0, 0, 0);
        step(0, 0, 0, 20'd0, 0, 0);
        step(0, 0, 0, {10'd470, 10'd630}, 0, 0);
        step(0, 0, 0, 20'd0, 0, 0);
        chk("clamp", 32'(position), 32'({10'd450, 10'd610}));

        // Reset during WAIT aborts the write; then hit-test boundaries.
        step(0, 1, 0, 20'd0, 0, 0);
        step(1, 0, 0, 20'd0, 0, 0);
        step(0, 0, 0, {10'd5, 10'd5}, 0, 0);
        chk("abort_status", 32'(status), 32'd1);
        for (int i = 0; i < N; i++) step(0, 0, 1, 20'd0, 0, 0);
        step(0, 0, 0, 20'd0, 46, 220);
        chk("hit_on", 32'(pixel_on), 32'd1);
        chk("hit_id", 32'(pixel_id), 32'd1);
        chk("hit_active", 32'(pixel_active), 32'd0);
        step(0, 0, 0, 20'd0, 45, 250);
        chk("miss_on", 32'(pixel_on), 32'd0);
        chk("miss_id", 32'(pixel_id), 32'd0);

        // Random traffic, biased toward square edges.
        for (int c = 0; c < 4000; c++) begin
            k = $urandom_range(N - 1, 0);
            if ($urandom_range(1, 0) == 1) begin
                px = m_x[k] + $urandom_range(35, 0);
                py = m_y[k] + $urandom_range(35, 0);
                px = (px >= 3) ? px - 3 : px;
                py = (py >= 3) ? py - 3 : py;
            end else begin
                px = $urandom_range(1023, 0);
                py = $urandom_range(1023, 0);
            end
            step(($urandom_range(199, 0) == 0),
                 ($urandom_range(5, 0) == 0),
                 ($urandom_range(4, 0) == 0),
                 20'($urandom),
                 px, py);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
